// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and read by the sprite mappers and palette stages.
// Every signal here is registered at the source and is aligned to the same pixel.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start
  );

  modport slave (
    input  DrawX, DrawY, blank, hs, vs, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: beam position, active-video flag, active-low syncs and
// line/frame strobes, all registered and decoded from the same next-state counter values.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W   = 10;
  localparam int CMP_W   = CNT_W + 1;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d must lie in 1..1024", H_TOTAL, V_TOTAL);
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CMP_W-1:0] H_VIS_C  = CMP_W'(H_VISIBLE);
  localparam logic [CMP_W-1:0] V_VIS_C  = CMP_W'(V_VISIBLE);
  localparam logic [CMP_W-1:0] HS_FIRST = CMP_W'(H_VISIBLE + H_FP);
  localparam logic [CMP_W-1:0] HS_LIMIT = CMP_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] VS_FIRST = CMP_W'(V_VISIBLE + V_FP);
  localparam logic [CMP_W-1:0] VS_LIMIT = CMP_W'(V_VISIBLE + V_FP + V_SYNC);

  function automatic logic is_active(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
    return ({1'b0, x} < H_VIS_C) && ({1'b0, y} < V_VIS_C);
  endfunction

  function automatic logic in_hsync(input logic [CNT_W-1:0] x);
    return ({1'b0, x} >= HS_FIRST) && ({1'b0, x} < HS_LIMIT);
  endfunction

  function automatic logic in_vsync(input logic [CNT_W-1:0] y);
    return ({1'b0, y} >= VS_FIRST) && ({1'b0, y} < VS_LIMIT);
  endfunction

  logic [CNT_W-1:0] hc_p0;
  logic [CNT_W-1:0] vc_p0;
  logic [CNT_W-1:0] hc_nxt;
  logic [CNT_W-1:0] vc_nxt;
  logic             hc_wrap;

  logic [CNT_W-1:0] drawx_p1;
  logic [CNT_W-1:0] drawy_p1;
  logic             blank_p1;
  logic             hs_p1;
  logic             vs_p1;
  logic             line_start_p1;
  logic             frame_start_p1;

  // Stage p0: raster counters. Reset parks them on the last pixel of the frame so the first
  // free-running edge lands on 0,0 and fires both strobes.
  always_comb begin
    hc_wrap = (hc_p0 == H_LAST);
    hc_nxt  = hc_wrap ? '0 : hc_p0 + CNT_W'(1);
    vc_nxt  = vc_p0;
    if (hc_wrap) begin
      vc_nxt = (vc_p0 == V_LAST) ? '0 : vc_p0 + CNT_W'(1);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_p0 <= H_LAST;
      vc_p0 <= V_LAST;
    end else begin
      hc_p0 <= hc_nxt;
      vc_p0 <= vc_nxt;
    end
  end

  // Stage p1: output registers, every flag decoded from the same next-state position.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      drawx_p1       <= '0;
      drawy_p1       <= '0;
      blank_p1       <= 1'b0;
      hs_p1          <= 1'b1;
      vs_p1          <= 1'b1;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      drawx_p1       <= hc_nxt;
      drawy_p1       <= vc_nxt;
      blank_p1       <= is_active(hc_nxt, vc_nxt);
      hs_p1          <= ~in_hsync(hc_nxt);
      vs_p1          <= ~in_vsync(vc_nxt);
      line_start_p1  <= (hc_nxt == '0);
      frame_start_p1 <= (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

  assign vif.DrawX       = drawx_p1;
  assign vif.DrawY       = drawy_p1;
  assign vif.blank       = blank_p1;
  assign vif.hs          = hs_p1;
  assign vif.vs          = vs_p1;
  assign vif.line_start  = line_start_p1;
  assign vif.frame_start = frame_start_p1;

endmodule
